// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK line levels, synchronizer depth
// and the synchronized line-event bundle passed from i2c_line_sync to the responder FSM.
package i2c_pkg;

    localparam int   SYNC_DEPTH = 2;
    localparam logic ACK_LVL    = 1'b0;
    localparam logic NACK_LVL   = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_MSB,
        WR_MSB_ACK,
        WR_LSB,
        WR_LSB_ACK,
        RD_MSB,
        RD_MSB_ACK,
        RD_LSB,
        RD_LSB_ACK,
        WAIT_STOP
    } i2c_state_e;

    typedef struct packed {
        logic sda;
        logic scl_rise;
        logic scl_fall;
        logic start;
        logic stop;
    } line_evt_t;

    // Open-drain: presenting a 0 on SDA means enabling the pull-down.
    function automatic logic oe_for_level(input logic lvl);
        return (lvl == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_slave_responder_if.sv
// I2C line bundle: scl/sda are the resolved line levels, sda_oe is the slave's pull-down enable.
// There is no valid/ready handshake on this bundle; levels are sampled asynchronously by the slave.
interface i2c_slave_responder_if;

    logic scl;
    logic sda;
    logic sda_oe;

    modport master (output scl, output sda, input sda_oe);
    modport slave  (input scl, input sda, output sda_oe);

endinterface

// File: rtl/i2c_line_sync.sv
// Two-stage synchronizers for SCL/SDA plus SCL edge and START/STOP detection on the synced copies.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst,
    i2c_slave_responder_if.slave  bus,
    output line_evt_t             evt_o
);

    logic [SYNC_DEPTH-1:0] scl_sync_q;
    logic [SYNC_DEPTH-1:0] sda_sync_q;
    logic                  scl_prev_q;
    logic                  sda_prev_q;
    logic                  scl_s;
    logic                  sda_s;

    // Everything resets to the idle-bus level so no edge is seen on reset release with a quiet bus.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_DEPTH-2:0], bus.scl};
            sda_sync_q <= {sda_sync_q[SYNC_DEPTH-2:0], bus.sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_DEPTH-1];
    assign sda_s = sda_sync_q[SYNC_DEPTH-1];

    always_comb begin
        evt_o          = '0;
        evt_o.sda      = sda_s;
        evt_o.scl_rise = scl_s & ~scl_prev_q;
        evt_o.scl_fall = ~scl_s & scl_prev_q;
        evt_o.start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        evt_o.stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave exposing four 16-bit registers: pointer byte, then MSB/LSB write or MSB/LSB read.
// All bus decisions are taken on synchronized SCL edges; SDA only changes on SCL falling edges.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'b1001000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Scl_in,
    input  logic        Sda_in,
    output logic        Sda_oe,
    output logic [1:0]  Rd_reg,
    input  logic [15:0] Rd_data,
    output logic        Wr_strobe,
    output logic [1:0]  Wr_reg,
    output logic [15:0] Wr_data,
    output logic        Busy,
    output logic        Nack_evt
);

    i2c_slave_responder_if line_if ();
    line_evt_t             evt;

    assign line_if.scl    = Scl_in;
    assign line_if.sda    = Sda_in;

    i2c_line_sync u_line_sync (
        .Clk   (Clk),
        .Rst   (Rst),
        .bus   (line_if),
        .evt_o (evt)
    );

    i2c_state_e  state_q,     state_d;
    logic [2:0]  bit_cnt_q,   bit_cnt_d;
    logic [6:0]  shift_q,     shift_d;
    logic [1:0]  ptr_q,       ptr_d;
    logic [7:0]  msb_q,       msb_d;
    logic [15:0] rd_buf_q,    rd_buf_d;
    logic        sda_oe_q,    sda_oe_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [1:0]  wr_reg_q,    wr_reg_d;
    logic [15:0] wr_data_q,   wr_data_d;
    logic        busy_q,      busy_d;
    logic        nack_evt_q,  nack_evt_d;
    logic [7:0]  byte_in;
    logic        last_bit;

    assign byte_in  = {shift_q, evt.sda};
    assign last_bit = (bit_cnt_q == 3'd7);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            msb_q       <= '0;
            rd_buf_q    <= '0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            nack_evt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            msb_q       <= msb_d;
            rd_buf_q    <= rd_buf_d;
            sda_oe_q    <= sda_oe_d;
            wr_strobe_q <= wr_strobe_d;
            wr_reg_q    <= wr_reg_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            nack_evt_q  <= nack_evt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        msb_d       = msb_q;
        rd_buf_d    = rd_buf_q;
        sda_oe_d    = sda_oe_q;
        wr_strobe_d = 1'b0;
        wr_reg_d    = wr_reg_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;
        nack_evt_d  = 1'b0;

        if (evt.stop) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = oe_for_level(NACK_LVL);
            busy_d    = 1'b0;
        end else if (evt.start) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
        end else if (evt.scl_rise) begin
            case (state_q)
                ADDR, PTR, WR_MSB, WR_LSB: begin
                    shift_d   = byte_in[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        case (state_q)
                            ADDR: begin
                                if (byte_in[7:1] == SLAVE_ADDR) begin
                                    state_d = ADDR_ACK;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = WAIT_STOP;
                                end
                            end
                            PTR: begin
                                if (byte_in[7:2] != 6'd0) begin
                                    state_d    = WAIT_STOP;
                                    nack_evt_d = 1'b1;
                                end else begin
                                    ptr_d   = byte_in[1:0];
                                    state_d = PTR_ACK;
                                end
                            end
                            WR_MSB: begin
                                // Register 0 is read-only, so its data phase is refused.
                                if (ptr_q == 2'd0) begin
                                    state_d    = WAIT_STOP;
                                    nack_evt_d = 1'b1;
                                end else begin
                                    msb_d   = byte_in;
                                    state_d = WR_MSB_ACK;
                                end
                            end
                            default: begin
                                state_d     = WR_LSB_ACK;
                                wr_strobe_d = 1'b1;
                                wr_reg_d    = ptr_q;
                                wr_data_d   = {msb_q, byte_in};
                            end
                        endcase
                    end
                end
                RD_MSB, RD_LSB: begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        state_d = (state_q == RD_MSB) ? RD_MSB_ACK : RD_LSB_ACK;
                    end
                end
                RD_MSB_ACK: state_d = (evt.sda == ACK_LVL) ? RD_LSB : WAIT_STOP;
                RD_LSB_ACK: state_d = WAIT_STOP;
                default: ;
            endcase
        end else if (evt.scl_fall) begin
            case (state_q)
                // First fall in an ACK state starts the ACK bit, the second one ends it.
                ADDR_ACK, PTR_ACK, WR_MSB_ACK, WR_LSB_ACK: begin
                    if (!sda_oe_q) begin
                        sda_oe_d = oe_for_level(ACK_LVL);
                    end else begin
                        sda_oe_d = oe_for_level(NACK_LVL);
                        case (state_q)
                            ADDR_ACK: begin
                                if (shift_q[0]) begin
                                    state_d  = RD_MSB;
                                    rd_buf_d = Rd_data;
                                    sda_oe_d = oe_for_level(Rd_data[15]);
                                end else begin
                                    state_d = PTR;
                                end
                            end
                            PTR_ACK:    state_d = WR_MSB;
                            WR_MSB_ACK: state_d = WR_LSB;
                            default:    state_d = WAIT_STOP;
                        endcase
                    end
                end
                RD_MSB:                 sda_oe_d = oe_for_level(rd_buf_q[{1'b1, ~bit_cnt_q}]);
                RD_LSB:                 sda_oe_d = oe_for_level(rd_buf_q[{1'b0, ~bit_cnt_q}]);
                RD_MSB_ACK, RD_LSB_ACK: sda_oe_d = oe_for_level(NACK_LVL);
                default: ;
            endcase
        end
    end

    assign line_if.sda_oe = sda_oe_q;
    assign Sda_oe         = line_if.sda_oe;
    assign Rd_reg         = ptr_q;
    assign Wr_strobe      = wr_strobe_q;
    assign Wr_reg         = wr_reg_q;
    assign Wr_data        = wr_data_q;
    assign Busy           = busy_q;
    assign Nack_evt       = nack_evt_q;

endmodule
